rsa_modexp_core: RTL



---
 rtl/rsa_pkg.sv | 37 +++
 rtl/rsa_montmul.sv | 80 ++++++++
 rtl/rsa_modexp_core.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared types and helpers for the modular-exponentiation core.
//   rsa_state_t : top-level sequencer states
//   mm_sel_t    : operand pair fed to the Montgomery multiplier
//   mm_cycles() / acc_w() : per-op cycle count and accumulator width for a given WIDTH
//   msb_index() : position of the highest set bit (0 when the value is 0)
package rsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE_M, ST_PRE_X, ST_LOOP_SQ, ST_LOOP_MUL, ST_POST, ST_DONE
  } rsa_state_t;

  typedef enum logic [2:0] {
    M_CONST, ONE_CONST, SQ, MUL, POST
  } mm_sel_t;

  function automatic int unsigned mm_cycles(input int unsigned width);
    return width + 2;
  endfunction

  function automatic int unsigned acc_w(input int unsigned width);
    return width + 2;
  endfunction

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned MM_CYCLES     = mm_cycles(DEFAULT_WIDTH);
  localparam int unsigned ACC_W         = acc_w(DEFAULT_WIDTH);

  function automatic int unsigned msb_index(input logic [63:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned b = 0; b < 64; b++) begin
      if (v[b]) idx = b;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rsa_montmul.sv
// Bit-serial Montgomery multiplier: r = a*b*2^-WIDTH mod n.
//   clk, rstb (sync, active-low), ena (freeze when low), clear (abort)
//   go   : load a/b/n and start an op (WIDTH+2 enabled cycles total)
//   a, b, n : operands, n odd
//   done : high during the correction cycle; r is valid in that same cycle
//   r    : corrected result (combinational off the accumulator)
module rsa_montmul
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             clear,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] r
);

  localparam int unsigned AW = acc_w(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {MM_IDLE, MM_ITER, MM_CORR} mm_phase_t;

  mm_phase_t        phase;
  logic [WIDTH-1:0] a_r, b_r, n_r;
  logic [AW-1:0]    acc;
  logic [CW-1:0]    cnt;

  logic [AW:0]      sum1, sum2;
  logic [AW-1:0]    acc_step, acc_corr;

  always_comb begin
    sum1     = (AW+1)'(acc) + (a_r[cnt] ? (AW+1)'(b_r) : '0);
    sum2     = sum1 + (sum1[0] ? (AW+1)'(n_r) : '0);
    acc_step = AW'(sum2 >> 1);
    acc_corr = (acc >= AW'(n_r)) ? (acc - AW'(n_r)) : acc;
    r        = WIDTH'(acc_corr);
    done     = (phase == MM_CORR);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      phase <= MM_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      n_r   <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (clear) begin
      phase <= MM_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else if (ena) begin
      if (go) begin
        a_r   <= a;
        b_r   <= b;
        n_r   <= n;
        acc   <= '0;
        cnt   <= '0;
        phase <= MM_ITER;
      end else begin
        case (phase)
          MM_ITER: begin
            acc <= acc_step;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) phase <= MM_CORR;
          end
          MM_CORR: phase <= MM_IDLE;
          default: phase <= MM_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/rsa_modexp_core.sv
// C = M^E mod P via left-to-right square-and-multiply on rsa_montmul.
//   clk, rstb (sync, active-low), ena (freeze), clear (abort to IDLE)
//   start : accepted in IDLE or DONE; latches P, E, M, Const
//   P, E, M, Const (= R^2 mod P) : WIDTH-bit operands
//   busy  : run in progress; eoc : result ready (level); err : P even/zero
//   C     : result, valid while eoc
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter bit          EXP_SKIP_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] E,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] Const,
  output logic             busy,
  output logic             eoc,
  output logic             err,
  output logic [WIDTH-1:0] C
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  rsa_state_t       state;
  mm_sel_t          sel;
  logic             go;
  logic [WIDTH-1:0] p_r, e_r, m_r, k_r, mb, xb;
  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] mm_a, mm_b, mm_r;
  logic             mm_done;

  always_comb begin
    mm_a = '0;
    mm_b = '0;
    case (sel)
      M_CONST:   begin mm_a = m_r; mm_b = k_r; end
      ONE_CONST: begin mm_a = ONE; mm_b = k_r; end
      SQ:        begin mm_a = xb;  mm_b = xb;  end
      MUL:       begin mm_a = mb;  mm_b = xb;  end
      POST:      begin mm_a = xb;  mm_b = ONE; end
      default:   begin mm_a = '0;  mm_b = '0;  end
    endcase
  end

  rsa_montmul #(.WIDTH(WIDTH)) u_mm (
    .clk   (clk),
    .rstb  (rstb),
    .ena   (ena),
    .clear (clear),
    .go    (go),
    .a     (mm_a),
    .b     (mm_b),
    .n     (p_r),
    .done  (mm_done),
    .r     (mm_r)
  );

  // Each op's result is captured on its correction edge and the next op is
  // issued by a registered go, so ops abut with no gap cycles.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= ST_IDLE;
      sel   <= M_CONST;
      go    <= 1'b0;
      busy  <= 1'b0;
      eoc   <= 1'b0;
      err   <= 1'b0;
      C     <= '0;
      p_r   <= '0;
      e_r   <= '0;
      m_r   <= '0;
      k_r   <= '0;
      mb    <= '0;
      xb    <= '0;
      idx   <= '0;
    end else if (clear) begin
      state <= ST_IDLE;
      go    <= 1'b0;
      busy  <= 1'b0;
      eoc   <= 1'b0;
      err   <= 1'b0;
      C     <= '0;
    end else if (ena) begin
      go <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            p_r <= P;
            e_r <= E;
            m_r <= M;
            k_r <= Const;
            C   <= '0;
            eoc <= 1'b0;
            err <= 1'b0;
            idx <= EXP_SKIP_LZ ? CW'(msb_index(64'(E))) : CW'(WIDTH - 1);
            if (!P[0]) begin
              state <= ST_DONE;
              eoc   <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= ST_PRE_M;
              sel   <= M_CONST;
              go    <= 1'b1;
              busy  <= 1'b1;
            end
          end
        end
        ST_PRE_M: if (mm_done) begin
          mb    <= mm_r;
          state <= ST_PRE_X;
          sel   <= ONE_CONST;
          go    <= 1'b1;
        end
        ST_PRE_X: if (mm_done) begin
          xb <= mm_r;
          go <= 1'b1;
          if (EXP_SKIP_LZ && (e_r == '0)) begin
            state <= ST_POST;
            sel   <= POST;
          end else begin
            state <= ST_LOOP_SQ;
            sel   <= SQ;
          end
        end
        ST_LOOP_SQ: if (mm_done) begin
          xb <= mm_r;
          go <= 1'b1;
          if (e_r[idx]) begin
            state <= ST_LOOP_MUL;
            sel   <= MUL;
          end else if (idx == '0) begin
            state <= ST_POST;
            sel   <= POST;
          end else begin
            idx <= idx - CW'(1);
            sel <= SQ;
          end
        end
        ST_LOOP_MUL: if (mm_done) begin
          xb <= mm_r;
          go <= 1'b1;
          if (idx == '0) begin
            state <= ST_POST;
            sel   <= POST;
          end else begin
            idx   <= idx - CW'(1);
            state <= ST_LOOP_SQ;
            sel   <= SQ;
          end
        end
        ST_POST: if (mm_done) begin
          C     <= mm_r;
          state <= ST_DONE;
          eoc   <= 1'b1;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
